uart_inst_loader: RTL

// - Writer side of the instruction-memory port the CPU fetches from: receives a program image over a UART line and writes it into the 64x32 instruction RAM.
// - Holds the CPU in reset while loading; releases it only after a checksum-verified image.
// - Sits beside the CPU in the top level: its mem_* outputs drive the instruction RAM write port, and cpu_hold is ORed into the CPU reset.

---
 rtl/uart_inst_loader_pkg.sv | 34 +++
 rtl/uart_rx_byte.sv | 100 ++++++++++
 rtl/uart_inst_loader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_inst_loader_pkg.sv
// ---------------------------------------------------------------------------
// uart_inst_loader_pkg : shared constants and state encodings | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_inst_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         MAX_WORDS = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_BITS  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // A word count is usable only if it is non-zero and fits the RAM.
  function automatic logic count_ok(input logic [7:0] n);
    return (n != 8'd0) && (n <= 8'(MAX_WORDS));
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte : 8N1 UART byte receiver with input synchroniser | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_byte
  import uart_inst_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state;
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RX_IDLE;
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        // A glitch shorter than half a bit is dropped here.
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= rx_sync ? RX_IDLE : RX_BITS;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_BITS: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_inst_loader.sv
// ---------------------------------------------------------------------------
// uart_inst_loader : loads a checksummed program image into instruction RAM
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_inst_loader
  import uart_inst_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int ADDR_W       = 6,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int              TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int              TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_LIMIT - 1);

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  load_state_t state;
  logic [7:0]  n_words;
  logic [7:0]  word_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  sum;
  logic [23:0] word;
  logic [TO_W-1:0] to_cnt;

  logic        active;
  logic [31:0] word_next;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  assign active    = (state == ST_COUNT) || (state == ST_DATA) || (state == ST_CHECK);
  assign word_next = {word, byte_data};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      n_words  <= 8'd0;
      word_idx <= 8'd0;
      byte_idx <= 2'd0;
      sum      <= 8'd0;
      word     <= 24'd0;
      to_cnt   <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= 32'd0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_we <= 1'b0;

      if (active) begin
        to_cnt <= byte_valid ? '0 : to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end

      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (byte_valid && (byte_data == SYNC_BYTE)) begin
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            state    <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (byte_valid) begin
            if (count_ok(byte_data)) begin
              n_words  <= byte_data;
              word_idx <= 8'd0;
              byte_idx <= 2'd0;
              sum      <= 8'd0;
              state    <= ST_DATA;
            end else begin
              err   <= 1'b1;
              state <= ST_ERROR;
            end
          end
        end
        ST_DATA: begin
          if (byte_valid) begin
            word     <= word_next[23:0];
            sum      <= sum + byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we   <= 1'b1;
              mem_addr <= word_idx[ADDR_W-1:0];
              mem_din  <= word_next;
              word_idx <= word_idx + 8'd1;
              if (word_idx == n_words - 8'd1) begin
                state <= ST_CHECK;
              end
            end
          end
        end
        ST_CHECK: begin
          if (byte_valid) begin
            if (byte_data == sum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= ST_DONE;
            end else begin
              err   <= 1'b1;
              state <= ST_ERROR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A byte arriving on the expiry cycle takes precedence over the timeout.
      if (active && !byte_valid && (frame_err || (to_cnt == TO_LAST))) begin
        err   <= 1'b1;
        state <= ST_ERROR;
      end
    end
  end

endmodule

`default_nettype wire
